// File: rtl/cve2_obi_mem_arbiter_pkg.sv
// Shared types and limits for the single-port OBI memory arbiter.
package cve2_obi_mem_arbiter_pkg;

  // Identifies which core interface issued a bus transaction.
  typedef enum logic {
    OBI_SRC_INSTR,
    OBI_SRC_DATA
  } obi_src_e;

  // Deepest source FIFO the arbiter supports; the count fits in ARB_CNT_W bits.
  localparam int unsigned ARB_MAX_OUTSTANDING_LIMIT = 4;
  localparam int unsigned ARB_CNT_W = 3;

endpackage

// File: rtl/cve2_obi_mem_arbiter_src_fifo.sv
// Register-based FIFO of transaction sources, kept in issue order so each
// in-order bus response can be routed back to the interface that asked for it.
module cve2_arb_src_fifo
  import cve2_obi_mem_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  obi_src_e             push_src,
  input  logic                 pop,
  output obi_src_e             head,
  output logic [ARB_CNT_W-1:0] count,
  output logic                 empty,
  output logic                 full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
  localparam logic [ARB_CNT_W-1:0] DepthCnt = ARB_CNT_W'(Depth);

  obi_src_e             mem [Depth];
  logic [PtrW-1:0]      rd_ptr_q;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [ARB_CNT_W-1:0] count_q;
  logic                 do_push;
  logic                 do_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthCnt);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  // A pop on an empty FIFO is dropped; a push into a full FIFO only lands if a pop frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_src;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cve2_obi_mem_arbiter.sv
// Shares one OBI memory port between instruction fetch and the LSU.
// Data wins by default, fetch is protected from starvation, a stalled request
// keeps its decision until granted, and responses are routed in issue order.
module cve2_obi_mem_arbiter
  import cve2_obi_mem_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,

  output logic [2:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  logic                 lock_q;
  obi_src_e             owner_q;
  logic [3:0]           starve_cnt_q;
  logic                 protocol_err_q;

  obi_src_e             winner;
  logic                 winner_valid;
  logic                 grant;
  logic                 resp_valid;

  obi_src_e             fifo_head;
  logic [ARB_CNT_W-1:0] fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;

  cve2_arb_src_fifo #(
    .Depth (MaxOutstanding)
  ) u_src_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (grant),
    .push_src (winner),
    .pop      (bus_rvalid_i),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Pick the winner: a locked decision stands, otherwise data unless fetch has waited too long.
  always_comb begin
    winner       = OBI_SRC_INSTR;
    winner_valid = 1'b0;
    if (lock_q) begin
      winner       = owner_q;
      winner_valid = (owner_q == OBI_SRC_DATA) ? data_req_i : instr_req_i;
    end else if (data_req_i && !(instr_req_i && (starve_cnt_q == StarveMax))) begin
      winner       = OBI_SRC_DATA;
      winner_valid = 1'b1;
    end else if (instr_req_i) begin
      winner       = OBI_SRC_INSTR;
      winner_valid = 1'b1;
    end
  end

  // Fullness uses the registered count, so a same-cycle response never re-opens the port early.
  assign bus_req_o   = winner_valid & ~fifo_full & rst_ni;
  assign grant       = bus_req_o & bus_gnt_i;
  assign instr_gnt_o = grant & (winner == OBI_SRC_INSTR);
  assign data_gnt_o  = grant & (winner == OBI_SRC_DATA);

  // Drive the winner's payload; fetches are always full-word reads.
  always_comb begin
    bus_addr_o  = instr_addr_i;
    bus_we_o    = 1'b0;
    bus_be_o    = 4'hF;
    bus_wdata_o = '0;
    if (winner == OBI_SRC_DATA) begin
      bus_addr_o  = data_addr_i;
      bus_we_o    = data_we_i;
      bus_be_o    = data_be_i;
      bus_wdata_o = data_wdata_i;
    end
  end

  // Responses with nothing outstanding are never forwarded.
  assign resp_valid     = bus_rvalid_i & ~fifo_empty & rst_ni;
  assign instr_rvalid_o = resp_valid & (fifo_head == OBI_SRC_INSTR);
  assign data_rvalid_o  = resp_valid & (fifo_head == OBI_SRC_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? bus_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? bus_rdata_i : '0;
  assign instr_err_o    = instr_rvalid_o & bus_err_i;
  assign data_err_o     = data_rvalid_o & bus_err_i;

  assign outstanding_o  = fifo_count;
  assign protocol_err_o = protocol_err_q;

  // Arbitration state: decision lock, fetch starvation counter and the stray-response flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q         <= 1'b0;
      owner_q        <= OBI_SRC_INSTR;
      starve_cnt_q   <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      if (bus_req_o && !bus_gnt_i) begin
        lock_q  <= 1'b1;
        owner_q <= winner;
      end else begin
        lock_q  <= 1'b0;
      end

      if (!instr_req_i || instr_gnt_o) begin
        starve_cnt_q <= '0;
      end else if (data_gnt_o && (starve_cnt_q != StarveMax)) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end

      protocol_err_q <= bus_rvalid_i & fifo_empty;
    end
  end

endmodule

// File: tb/tb_cve2_obi_mem_arbiter.sv
// Self-checking bench for the OBI memory arbiter: a queue-based reference
// model is compared every cycle, plus directed literal checks per scenario.
module tb_cve2_obi_mem_arbiter;

  localparam int MAX_OUT = 2;
  localparam int STARVE  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_gnt, bus_rvalid, bus_we, bus_err;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  outstanding;
  logic        protocol_err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: sources in flight (0 = fetch, 1 = data), held decision, starvation count.
  int src_q[$];
  bit m_lock;
  int m_owner;
  int m_starve;
  bit m_perr;

  bit          e_req, e_igt, e_dgt, e_irv, e_drv;
  int          e_win;
  logic [31:0] e_addr, e_wdata;
  logic        e_we;
  logic [3:0]  e_be;

  always #5 clk = ~clk;

  cve2_obi_mem_arbiter #(
    .MaxOutstanding (MAX_OUT),
    .StarveLimit    (STARVE)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .instr_req_i    (instr_req),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_addr_i   (instr_addr),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .data_req_i     (data_req),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .bus_req_o      (bus_req),
    .bus_gnt_i      (bus_gnt),
    .bus_rvalid_i   (bus_rvalid),
    .bus_we_o       (bus_we),
    .bus_be_o       (bus_be),
    .bus_addr_o     (bus_addr),
    .bus_wdata_o    (bus_wdata),
    .bus_rdata_i    (bus_rdata),
    .bus_err_i      (bus_err),
    .outstanding_o  (outstanding),
    .protocol_err_o (protocol_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input bit rst, input bit ireq, input logic [31:0] iaddr,
                               input bit dreq, input bit dwe, input logic [3:0] dbe,
                               input logic [31:0] daddr, input logic [31:0] dwdata,
                               input bit gnt, input bit rv, input logic [31:0] rdata,
                               input bit err);
    @(posedge clk);
    #1;
    rst_n      = rst;
    instr_req  = ireq;
    instr_addr = iaddr;
    data_req   = dreq;
    data_we    = dwe;
    data_be    = dbe;
    data_addr  = daddr;
    data_wdata = dwdata;
    bus_gnt    = gnt;
    bus_rvalid = rv;
    bus_rdata  = rdata;
    bus_err    = err;
  endtask

  task automatic idleCycle(input bit rv);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, rv, 32'h0, 0);
  endtask

  // Expected outputs from the model state and the current inputs.
  task automatic compute_expected();
    bit have;
    have  = 0;
    e_win = 0;
    if (m_lock) begin
      e_win = m_owner;
      have  = (m_owner == 1) ? bit'(data_req) : bit'(instr_req);
    end else if (data_req && !(instr_req && m_starve >= STARVE)) begin
      e_win = 1;
      have  = 1;
    end else if (instr_req) begin
      e_win = 0;
      have  = 1;
    end
    e_req = rst_n && have && (src_q.size() < MAX_OUT);
    e_igt = e_req && bus_gnt && (e_win == 0);
    e_dgt = e_req && bus_gnt && (e_win == 1);
    e_irv = rst_n && bus_rvalid && (src_q.size() > 0) && (src_q[0] == 0);
    e_drv = rst_n && bus_rvalid && (src_q.size() > 0) && (src_q[0] == 1);
    if (e_win == 1) begin
      e_addr = data_addr; e_we = data_we; e_be = data_be; e_wdata = data_wdata;
    end else begin
      e_addr = instr_addr; e_we = 1'b0; e_be = 4'hF; e_wdata = 32'h0;
    end
  endtask

  // Advance the model at each rising edge with the inputs of the cycle just ending.
  always @(posedge clk) begin
    compute_expected();
    if (!rst_n) begin
      src_q.delete();
      m_lock   = 0;
      m_owner  = 0;
      m_starve = 0;
      m_perr   = 0;
    end else begin
      m_perr = bus_rvalid && (src_q.size() == 0);
      if (bus_rvalid && src_q.size() > 0) void'(src_q.pop_front());
      if (e_req && bus_gnt) src_q.push_back(e_win);
      m_lock  = e_req && !bus_gnt;
      m_owner = e_win;
      if (!instr_req || e_igt) m_starve = 0;
      else if (e_dgt && m_starve < STARVE) m_starve++;
    end
  end

  // Compare every DUT output against the model once per cycle, away from the rising edge.
  always @(negedge clk) begin
    compute_expected();
    checkOutput("bus_req", bus_req, e_req);
    checkOutput("instr_gnt", instr_gnt, e_igt);
    checkOutput("data_gnt", data_gnt, e_dgt);
    checkOutput("instr_rvalid", instr_rvalid, e_irv);
    checkOutput("data_rvalid", data_rvalid, e_drv);
    checkOutput("instr_rdata", instr_rdata, e_irv ? bus_rdata : 32'h0);
    checkOutput("data_rdata", data_rdata, e_drv ? bus_rdata : 32'h0);
    checkOutput("instr_err", instr_err, e_irv && bus_err);
    checkOutput("data_err", data_err, e_drv && bus_err);
    checkOutput("outstanding", outstanding, src_q.size());
    checkOutput("protocol_err", protocol_err, m_perr);
    if (e_req) begin
      checkOutput("bus_addr", bus_addr, e_addr);
      checkOutput("bus_we", bus_we, e_we);
      checkOutput("bus_be", bus_be, e_be);
      checkOutput("bus_wdata", bus_wdata, e_wdata);
    end
  end

  initial begin
    logic [1:0] pat [10];
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    rst_n = 0; instr_req = 0; instr_addr = 0; data_req = 0; data_we = 0; data_be = 0;
    data_addr = 0; data_wdata = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;

    // Reset: requests and responses must be suppressed.
    applyStimulus(0, 1, 32'h100, 1, 0, 4'hF, 32'h2000, 0, 1, 1, 32'h5, 0);
    @(negedge clk);
    checkOutput("reset_bus_req", bus_req, 0);
    checkOutput("reset_gnt", {instr_gnt, data_gnt}, 0);
    checkOutput("reset_rvalid", {instr_rvalid, data_rvalid}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("reset_outstanding", outstanding, 0);

    // Data-priority collision.
    applyStimulus(1, 1, 32'h100, 1, 0, 4'hF, 32'h2000, 0, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("coll_data_gnt", data_gnt, 1);
    checkOutput("coll_instr_gnt", instr_gnt, 0);
    checkOutput("coll_addr_data", bus_addr, 32'h2000);
    applyStimulus(1, 1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h1111_1111, 0);
    @(negedge clk);
    checkOutput("coll_instr_gnt2", instr_gnt, 1);
    checkOutput("coll_addr_instr", bus_addr, 32'h100);
    checkOutput("coll_data_rvalid", data_rvalid, 1);
    checkOutput("coll_data_rdata", data_rdata, 32'h1111_1111);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_2222, 0);
    @(negedge clk);
    checkOutput("coll_instr_rvalid", instr_rvalid, 1);
    checkOutput("coll_instr_rdata", instr_rdata, 32'h2222_2222);
    checkOutput("coll_data_rvalid2", data_rvalid, 0);

    // Lock hold: a stalled fetch keeps the port even when data arrives.
    applyStimulus(1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lock_addr0", bus_addr, 32'h80);
    for (int i = 1; i < 3; i++) begin
      applyStimulus(1, 1, 32'h80, 1, 0, 4'hF, 32'h3000, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("lock_addr_held", bus_addr, 32'h80);
      checkOutput("lock_no_data_gnt", data_gnt, 0);
    end
    applyStimulus(1, 1, 32'h80, 1, 0, 4'hF, 32'h3000, 0, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("lock_instr_gnt", instr_gnt, 1);
    checkOutput("lock_addr_gnt", bus_addr, 32'h80);
    applyStimulus(1, 0, 0, 1, 0, 4'hF, 32'h3000, 0, 1, 1, 32'hAAAA_0001, 0);
    @(negedge clk);
    checkOutput("lock_data_gnt", data_gnt, 1);
    checkOutput("lock_data_addr", bus_addr, 32'h3000);
    checkOutput("lock_instr_rvalid", instr_rvalid, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_0002, 0);
    @(negedge clk);
    checkOutput("lock_data_rvalid", data_rvalid, 1);

    // Starvation guard: four data grants, then one fetch grant, repeating.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 32'h400, 1, 0, 4'hF, 32'h5000, 0, 1, (i != 0), 32'h100 + i, 0);
      @(negedge clk);
      checkOutput("starve_pattern", {instr_gnt, data_gnt}, pat[i]);
    end
    idleCycle(1);
    @(negedge clk);
    checkOutput("starve_drained_rv", instr_rvalid, 1);

    // Outstanding limit with responses withheld.
    applyStimulus(1, 0, 0, 1, 0, 4'hF, 32'h6000, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 4'hF, 32'h6004, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 4'hF, 32'h6008, 0, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_bus_req", bus_req, 0);
    checkOutput("full_outstanding", outstanding, 2);
    checkOutput("full_data_gnt", data_gnt, 0);
    applyStimulus(1, 0, 0, 1, 0, 4'hF, 32'h6008, 0, 1, 1, 32'h6, 0);
    @(negedge clk);
    checkOutput("full_pop_bus_req", bus_req, 0);
    checkOutput("full_pop_rvalid", data_rvalid, 1);
    applyStimulus(1, 0, 0, 1, 0, 4'hF, 32'h6008, 0, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_reopen_bus_req", bus_req, 1);
    checkOutput("full_reopen_outstanding", outstanding, 1);
    idleCycle(1);
    idleCycle(1);
    idleCycle(0);
    @(negedge clk);
    checkOutput("full_drained", outstanding, 0);

    // Error routing, then a stray response.
    applyStimulus(1, 0, 0, 1, 1, 4'h3, 32'h7000, 32'hDEAD_BEEF, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("err_bus_we", bus_we, 1);
    checkOutput("err_bus_be", bus_be, 4'h3);
    checkOutput("err_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1);
    @(negedge clk);
    checkOutput("err_data_err", data_err, 1);
    checkOutput("err_instr_err", instr_err, 0);
    idleCycle(0);
    idleCycle(1);
    @(negedge clk);
    checkOutput("stray_not_forwarded", {instr_rvalid, data_rvalid}, 0);
    checkOutput("stray_perr_before", protocol_err, 0);
    idleCycle(0);
    @(negedge clk);
    checkOutput("stray_perr", protocol_err, 1);
    idleCycle(0);
    @(negedge clk);
    checkOutput("stray_perr_pulse", protocol_err, 0);

    // Reset with two transactions in flight.
    applyStimulus(1, 1, 32'h900, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 4'hF, 32'hA000, 0, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_mid_gnt_before", data_gnt, 1);
    applyStimulus(0, 1, 32'h904, 1, 0, 4'hF, 32'hA004, 0, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_mid_bus_req", bus_req, 0);
    checkOutput("rst_mid_gnt", {instr_gnt, data_gnt}, 0);
    idleCycle(1);
    @(negedge clk);
    checkOutput("rst_mid_outstanding", outstanding, 0);
    checkOutput("rst_mid_no_rvalid", {instr_rvalid, data_rvalid}, 0);
    idleCycle(0);
    @(negedge clk);
    checkOutput("rst_mid_perr", protocol_err, 1);
    idleCycle(0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cve2_obi_mem_arbiter.md
Name: cve2_obi_mem_arbiter

Overview:
Shares a single OBI-style memory port between the core's instruction-fetch and data (LSU) interfaces, for single-port-memory integrations of cve2_top. The block does three things:
- Arbitrates requests: data has priority, with a starvation guard for fetch.
- Holds its arbitration decision stable until the bus grants.
- Tracks outstanding transactions in issue order, so each in-order response is routed to the requester that issued it.

Parameters:
- MaxOutstanding, 2: maximum number of granted-but-unanswered bus transactions (1..4).
- StarveLimit, 4: maximum number of consecutive data grants while instr_req_i is pending; the next arbitration then goes to instr (1..15).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- instr_req_i  in  1  fetch request.
- instr_gnt_o  out  1  fetch grant.
- instr_rvalid_o  out  1  fetch response valid.
- instr_addr_i  in  32  fetch address.
- instr_rdata_o  out  32  fetch read data.
- instr_err_o  out  1  fetch bus error.
- data_req_i  in  1  data request.
- data_gnt_o  out  1  data grant.
- data_rvalid_o  out  1  data response valid.
- data_we_i  in  1  data write enable.
- data_be_i  in  4  data byte enables.
- data_addr_i  in  32  data address.
- data_wdata_i  in  32  data write data.
- data_rdata_o  out  32  data read data.
- data_err_o  out  1  data bus error.
- bus_req_o  out  1  shared-port request.
- bus_gnt_i  in  1  shared-port grant.
- bus_rvalid_i  in  1  shared-port response valid.
- bus_we_o  out  1  shared-port write enable.
- bus_be_o  out  4  shared-port byte enables.
- bus_addr_o  out  32  shared-port address.
- bus_wdata_o  out  32  shared-port write data.
- bus_rdata_i  in  32  shared-port read data.
- bus_err_i  in  1  shared-port error.
- outstanding_o  out  3  current outstanding count.
- protocol_err_o  out  1  registered, one-cycle pulse: bus_rvalid_i seen with nothing outstanding.

Behaviour:
- State: lock_q (1b), owner_q (obi_src_e), starve_cnt_q (4b), and the source FIFO (count, read pointer, write pointer).
- Reset (rst_ni low at a clk_i edge):
  - Clears lock_q, starve_cnt_q, the FIFO and protocol_err_o.
  - While rst_ni is low, bus_req_o, both gnt and both rvalid outputs are forced 0.
  - Reset mid-transaction discards outstanding IDs. Any bus_rvalid_i arriving after reset raises protocol_err_o and is not forwarded.
- Arbitration (combinational, zero latency, request to bus_req_o):
  - full = (count == MaxOutstanding).
  - If full: bus_req_o = 0 and both gnt outputs = 0.
  - If lock_q = 1: the winner is owner_q.
  - Otherwise the winner is data when data_req_i = 1, except instr wins when instr_req_i = 1 and starve_cnt_q == StarveLimit.
  - Otherwise the winner is instr when only instr_req_i = 1.
  - bus_req_o = 1 whenever a winner exists and the FIFO is not full.
- Payload muxing:
  - bus payload = winner's fields.
  - For an instr winner: bus_we_o = 0, bus_be_o = 4'hF, bus_wdata_o = 0.
- Grant: winner gnt_o = bus_req_o & bus_gnt_i; the loser's gnt_o = 0.
- Lock (payload stability):
  - If bus_req_o = 1 and bus_gnt_i = 0, set lock_q = 1 and owner_q = winner.
  - Clear lock_q on the granting cycle.
  - Requesters must hold req and payload until gnt.
- Starvation counter:
  - Increments (saturating at StarveLimit) on a data grant while instr_req_i = 1.
  - Clears on an instr grant, or on any cycle where instr_req_i = 0.
- Source FIFO (cve2_arb_src_fifo):
  - Push the winner ID on every grant; pop on bus_rvalid_i.
  - Response routing:
    - head = INSTR: instr_rvalid_o = 1, instr_rdata_o = bus_rdata_i, instr_err_o = bus_err_i.
    - head = DATA: the same, on the data_* response outputs.
    - Non-selected rvalid = 0; non-selected rdata = 0.
  - Push and pop in the same cycle: count unchanged, including when full. full is evaluated on count_q, so a same-cycle pop does not re-enable the request.
  - Pop on empty: ignored, protocol_err_o = 1 on the next cycle.
- Responses are strictly in issue order. Zero-wait bus behaviour (gnt in the request cycle, rvalid the next cycle) sustains one transaction per cycle when MaxOutstanding ≥ 2.

Decomposition:
- cve2_pkg gains:
  - typedef enum logic {OBI_SRC_INSTR, OBI_SRC_DATA} obi_src_e;
  - localparam int unsigned ARB_MAX_OUTSTANDING_LIMIT = 4.
- One sub-module, cve2_arb_src_fifo: synchronous-reset, register-based FIFO of obi_src_e. Parameter Depth; ports push/pop/head/count/empty/full.

Test Plan:
- Data-priority collision: both requests asserted at 0x100 (instr) and 0x2000 (data), bus_gnt_i = 1 each cycle → data granted first, instr next cycle; responses route to data, then instr.
- Lock hold: instr alone at 0x80, bus_gnt_i = 0 for 3 cycles; data_req_i rises in cycle 1 → bus_addr_o stays 0x80 until grant; data granted the following cycle.
- Starvation guard: StarveLimit = 4, data_req_i and instr_req_i continuously high → grant pattern D,D,D,D,I repeating.
- Outstanding limit: MaxOutstanding = 2, rvalid withheld → after 2 grants bus_req_o = 0 and outstanding_o = 2. One rvalid → count drops to 1 and bus_req_o returns to 1 the next cycle.
- Error routing / protocol error: data write 0xDEADBEEF with be = 4'h3 gets bus_err_i = 1 on rvalid → data_err_o = 1, instr_err_o = 0. A later spurious bus_rvalid_i → protocol_err_o = 1 for one cycle.
- Reset mid-operation: two transactions outstanding, rst_ni low for 1 cycle → outstanding_o = 0, no gnt/rvalid during reset; a late rvalid → protocol_err_o = 1 and no rvalid is forwarded.
